// File: rtl/mac_seq_pkg.sv
// Shared constants for the MAC sequencer: FSM one-hot codes, Q8.8 helpers and saturation.
package mac_seq_pkg;

   localparam logic [3:0] IDLE        = 4'b0001;
   localparam logic [3:0] LOAD_W      = 4'b0010;
   localparam logic [3:0] CALCULATION = 4'b0100;
   localparam logic [3:0] DONE        = 4'b1000;

   localparam int          FRACTIONAL_BITS = 8;
   localparam logic [15:0] ONE             = 16'h0100;

   // Clamp a signed value to the signed range of a dw-bit word; caller truncates to dw bits.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int unsigned dw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 32'd1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 32'd1));
      if (v > hi) begin
         saturate = hi;
      end else if (v < lo) begin
         saturate = lo;
      end else begin
         saturate = v;
      end
   endfunction

endpackage

// File: rtl/mac_seq_if.sv
// Bundle of control, weight, feature-buffer and multiplier signals around mac_sequencer.
interface mac_seq_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5
);
   logic                  start;
   logic                  keep_w;
   logic [DATA_WIDTH-1:0] bias;
   logic                  w_valid;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  w_ready;
   logic [ADDR_WIDTH-1:0] x_addr;
   logic                  x_rd;
   logic [DATA_WIDTH-1:0] x_data;
   logic [DATA_WIDTH-1:0] mult_a;
   logic [DATA_WIDTH-1:0] mult_b;
   logic [DATA_WIDTH-1:0] mult_p;
   logic                  busy;
   logic [DATA_WIDTH-1:0] result;
   logic                  result_valid;

   modport slave (
      input  start, keep_w, bias, w_valid, w_data, x_data, mult_p,
      output w_ready, x_addr, x_rd, mult_a, mult_b, busy, result, result_valid
   );

   modport master (
      output start, keep_w, bias, w_valid, w_data, x_data, mult_p,
      input  w_ready, x_addr, x_rd, mult_a, mult_b, busy, result, result_valid
   );
endinterface

// File: rtl/mac_seq_wbuf.sv
// KERNEL_LEN-entry weight register file: one write port, one registered read port.
module mac_seq_wbuf #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5,
   parameter int KERNEL_LEN = 25
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(KERNEL_LEN - 1);

   logic [DATA_WIDTH-1:0] mem_r [KERNEL_LEN];
   logic [DATA_WIDTH-1:0] rdata_r;

   // Kernel storage, deliberately left uncleared by reset.
   always_ff @(posedge clk) begin
      if (we && (waddr <= LAST_IDX)) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Registered read port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_r <= {DATA_WIDTH{1'b0}};
      end else if (raddr <= LAST_IDX) begin
         rdata_r <= mem_r[raddr];
      end else begin
         rdata_r <= {DATA_WIDTH{1'b0}};
      end
   end

   assign rdata = rdata_r;
endmodule

// File: rtl/mac_sequencer.sv
// Drives an external Q8.8 multiplier through a KERNEL_LEN-tap dot product plus bias.
// Build option: MAC_SEQ_RELU_EN clamps negative results to zero.
module mac_sequencer
   import mac_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int KERNEL_LEN = 25,
   parameter int ADDR_WIDTH = 5
) (
   input logic     clk,
   input logic     rst_n,
   mac_seq_if.slave bus
);
   localparam int                    CNT_W     = $clog2(KERNEL_LEN + 3);
   localparam logic [CNT_W-1:0]      LAST_TAP  = CNT_W'(KERNEL_LEN - 1);
   localparam logic [CNT_W-1:0]      LAST_CALC = CNT_W'(KERNEL_LEN + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_W    = ADDR_WIDTH'(KERNEL_LEN - 1);

   logic [3:0]                   state_r;
   logic [ADDR_WIDTH-1:0]        wcnt_r;
   logic [CNT_W-1:0]             ccnt_r;
   logic                         v1_r;
   logic                         v2_r;
   logic signed [ACC_WIDTH-1:0]  acc_r;
   logic signed [DATA_WIDTH-1:0] bias_r;
   logic [DATA_WIDTH-1:0]        result_r;
   logic                         result_valid_r;

   logic                         issue_s;
   logic                         we_s;
   logic [DATA_WIDTH-1:0]        wbuf_rdata_s;
   logic signed [ACC_WIDTH-1:0]  acc_nxt_s;
   logic signed [ACC_WIDTH:0]    sum_s;
   logic [DATA_WIDTH-1:0]        sat_s;
   logic [DATA_WIDTH-1:0]        result_nxt_s;

   assign issue_s = (state_r == CALCULATION) && (ccnt_r <= LAST_TAP);
   assign we_s    = (state_r == LOAD_W) && bus.w_valid;

   mac_seq_wbuf #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .KERNEL_LEN(KERNEL_LEN)
   ) u_wbuf (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (we_s),
      .waddr(wcnt_r),
      .wdata(bus.w_data),
      .raddr(ADDR_WIDTH'(ccnt_r)),
      .rdata(wbuf_rdata_s)
   );

   // Final sum folds in the product landing on the last CALCULATION cycle.
   always_comb begin
      acc_nxt_s = acc_r;
      if (v2_r) begin
         acc_nxt_s = acc_r + ACC_WIDTH'($signed(bus.mult_p));
      end else begin
         acc_nxt_s = acc_r;
      end
      sum_s = (ACC_WIDTH + 1)'(acc_nxt_s) + (ACC_WIDTH + 1)'(bias_r);
      sat_s = DATA_WIDTH'(saturate(64'(sum_s), DATA_WIDTH));
`ifdef MAC_SEQ_RELU_EN
      if (sat_s[DATA_WIDTH-1]) begin
         result_nxt_s = {DATA_WIDTH{1'b0}};
      end else begin
         result_nxt_s = sat_s;
      end
`else
      result_nxt_s = sat_s;
`endif
   end

   // Control FSM, pipeline valids and accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         wcnt_r         <= {ADDR_WIDTH{1'b0}};
         ccnt_r         <= {CNT_W{1'b0}};
         v1_r           <= 1'b0;
         v2_r           <= 1'b0;
         acc_r          <= {ACC_WIDTH{1'b0}};
         bias_r         <= {DATA_WIDTH{1'b0}};
         result_r       <= {DATA_WIDTH{1'b0}};
         result_valid_r <= 1'b0;
      end else begin
         v1_r           <= issue_s;
         v2_r           <= v1_r;
         result_valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  bias_r  <= bus.bias;
                  acc_r   <= {ACC_WIDTH{1'b0}};
                  wcnt_r  <= {ADDR_WIDTH{1'b0}};
                  ccnt_r  <= {CNT_W{1'b0}};
                  state_r <= bus.keep_w ? CALCULATION : LOAD_W;
               end
            end
            LOAD_W: begin
               if (bus.w_valid) begin
                  wcnt_r <= wcnt_r + ADDR_WIDTH'(1'b1);
                  if (wcnt_r == LAST_W) begin
                     state_r <= CALCULATION;
                  end
               end
            end
            CALCULATION: begin
               acc_r  <= acc_nxt_s;
               ccnt_r <= ccnt_r + CNT_W'(1'b1);
               if (ccnt_r == LAST_CALC) begin
                  state_r        <= DONE;
                  result_r       <= result_nxt_s;
                  result_valid_r <= 1'b1;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.w_ready      = (state_r == LOAD_W);
   assign bus.busy         = (state_r != IDLE);
   assign bus.x_rd         = issue_s;
   assign bus.x_addr       = issue_s ? ADDR_WIDTH'(ccnt_r) : {ADDR_WIDTH{1'b0}};
   assign bus.mult_a       = v1_r ? bus.x_data : {DATA_WIDTH{1'b0}};
   assign bus.mult_b       = v1_r ? wbuf_rdata_s : {DATA_WIDTH{1'b0}};
   assign bus.result       = result_r;
   assign bus.result_valid = result_valid_r;
endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a Q8.8 multiplier model and a 1-cycle feature buffer.
module tb_mac_sequencer;
   import mac_seq_pkg::*;

   localparam int DW = 16;
   localparam int AW = 5;
   localparam int K  = 25;
`ifdef MAC_SEQ_RELU_EN
   localparam logic [15:0] EXP_NEG  = 16'h0000;
   localparam logic [15:0] EXP_NSAT = 16'h0000;
`else
   localparam logic [15:0] EXP_NEG  = 16'hE780;
   localparam logic [15:0] EXP_NSAT = 16'h8000;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mac_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

   mac_sequencer #(
      .DATA_WIDTH(DW), .ACC_WIDTH(32), .KERNEL_LEN(K), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   logic [15:0] xmem [32];
   logic [15:0] wmem [32];
   logic signed [31:0] prod_s;

   assign prod_s = $signed(bus.mult_a) * $signed(bus.mult_b);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.mult_p <= 16'h0000;
      else        bus.mult_p <= prod_s[23:8];
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)         bus.x_data <= 16'h0000;
      else if (bus.x_rd)  bus.x_data <= xmem[bus.x_addr];
   end

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] job_res;
   int job_calc, job_nvalid, job_wacc, job_wrdy, job_xrd;
   bit job_timeout;

   task automatic fill(input logic [15:0] wv, input logic [15:0] xv);
      for (int i = 0; i < 32; i++) begin
         wmem[i] = wv;
         xmem[i] = xv;
      end
   endtask

   task automatic run_job(input logic keep, input logic [15:0] b, input bit gap, input bit extra);
      int cyc;
      bit phase;
      cyc = 0; phase = 1'b0;
      job_res = 16'h0000; job_calc = 0; job_nvalid = 0; job_wacc = 0;
      job_wrdy = 0; job_xrd = 0; job_timeout = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.keep_w = keep; bus.bias = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.keep_w = 1'b0; bus.bias = 16'h0000;
      while (bus.busy === 1'b1 && cyc < 300) begin
         if (bus.w_ready === 1'b1) job_wrdy++;
         if (bus.x_rd === 1'b1) job_xrd++;
         if (bus.result_valid === 1'b1) begin
            job_nvalid++;
            job_res = bus.result;
         end else if (bus.w_ready === 1'b0) begin
            job_calc++;
         end
         bus.w_valid = 1'b0;
         if (bus.w_ready === 1'b1 && (!gap || phase)) begin
            bus.w_valid = 1'b1;
            bus.w_data  = wmem[job_wacc % 32];
            job_wacc++;
         end
         bus.start = extra && (((cyc % 5) == 2) || (bus.result_valid === 1'b1));
         phase = !phase;
         cyc++;
         @(posedge clk); #1;
      end
      bus.w_valid = 1'b0;
      bus.start   = 1'b0;
      if (cyc >= 300) job_timeout = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({bus.busy, bus.result_valid, bus.w_ready, bus.x_rd} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 0000", {bus.busy, bus.result_valid, bus.w_ready, bus.x_rd});
      end
      n_tests++;
      if (bus.result !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_result: got %h expected 0000", bus.result);
      end
      n_tests++;
      if ({bus.mult_a, bus.mult_b, bus.x_addr} !== 37'h0) begin
         n_fail++;
         $display("FAIL reset_operands: got %h %h %h expected 0", bus.mult_a, bus.mult_b, bus.x_addr);
      end
   endtask

   task automatic test_unity();
      fill(ONE, ONE);
      run_job(1'b0, 16'h0000, 1'b0, 1'b0);
      n_tests++;
      if (job_res !== 16'h1900 || job_timeout) begin
         n_fail++;
         $display("FAIL unity_result: got %h expected 1900 (timeout=%0d)", job_res, job_timeout);
      end
      n_tests++;
      if (job_nvalid !== 1) begin
         n_fail++;
         $display("FAIL unity_valid_pulses: got %0d expected 1", job_nvalid);
      end
      n_tests++;
      if (job_calc !== K + 2) begin
         n_fail++;
         $display("FAIL unity_calc_cycles: got %0d expected %0d", job_calc, K + 2);
      end
      n_tests++;
      if (job_wacc !== K || job_xrd !== K) begin
         n_fail++;
         $display("FAIL unity_counts: got w=%0d x=%0d expected %0d", job_wacc, job_xrd, K);
      end
   endtask

   task automatic test_negative();
      fill(16'hFF00, ONE);
      run_job(1'b0, 16'h0080, 1'b0, 1'b0);
      n_tests++;
      if (job_res !== EXP_NEG || job_nvalid !== 1) begin
         n_fail++;
         $display("FAIL negative_result: got %h (n=%0d) expected %h", job_res, job_nvalid, EXP_NEG);
      end
   endtask

   task automatic test_saturation();
      fill(ONE, 16'h7F00);
      run_job(1'b0, 16'h0000, 1'b0, 1'b0);
      n_tests++;
      if (job_res !== 16'h7FFF) begin
         n_fail++;
         $display("FAIL sat_positive: got %h expected 7fff", job_res);
      end
      fill(16'h8000, ONE);
      run_job(1'b0, 16'h0000, 1'b0, 1'b0);
      n_tests++;
      if (job_res !== EXP_NSAT) begin
         n_fail++;
         $display("FAIL sat_negative: got %h expected %h", job_res, EXP_NSAT);
      end
   endtask

   task automatic test_keep_w();
      fill(16'h0200, ONE);
      run_job(1'b0, 16'h0000, 1'b0, 1'b0);
      n_tests++;
      if (job_res !== 16'h3200) begin
         n_fail++;
         $display("FAIL keepw_load_result: got %h expected 3200", job_res);
      end
      fill(16'h7F00, 16'h0080);
      run_job(1'b1, ONE, 1'b0, 1'b0);
      n_tests++;
      if (job_res !== 16'h1A00) begin
         n_fail++;
         $display("FAIL keepw_reuse_result: got %h expected 1a00", job_res);
      end
      n_tests++;
      if (job_wrdy !== 0 || job_calc !== K + 2) begin
         n_fail++;
         $display("FAIL keepw_no_load: got wrdy=%0d calc=%0d expected 0 and %0d", job_wrdy, job_calc, K + 2);
      end
   endtask

   task automatic test_gapped_weights();
      int busy_after;
      for (int i = 0; i < 32; i++) begin
         wmem[i] = 16'(i * 16);
         xmem[i] = (i % 2 == 0) ? ONE : 16'h0000;
      end
      run_job(1'b0, 16'h0000, 1'b1, 1'b1);
      n_tests++;
      if (job_wacc !== K) begin
         n_fail++;
         $display("FAIL gap_words_accepted: got %0d expected %0d", job_wacc, K);
      end
      n_tests++;
      if (job_res !== 16'h09C0 || job_nvalid !== 1) begin
         n_fail++;
         $display("FAIL gap_result: got %h (n=%0d) expected 09c0 (n=1)", job_res, job_nvalid);
      end
      busy_after = 0;
      repeat (3) begin
         if (bus.busy !== 1'b0) busy_after++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (busy_after !== 0) begin
         n_fail++;
         $display("FAIL gap_start_in_done: got %0d busy cycles expected 0", busy_after);
      end
   endtask

   task automatic test_abort();
      int stray;
      fill(ONE, ONE);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.keep_w = 1'b1; bus.bias = 16'h0000;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.keep_w = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({bus.busy, bus.result_valid, bus.x_rd} !== 3'b000 || bus.result !== 16'h0000) begin
         n_fail++;
         $display("FAIL abort_state: got busy=%b rv=%b xrd=%b res=%h expected 0", bus.busy, bus.result_valid, bus.x_rd, bus.result);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      stray = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) stray++;
      end
      n_tests++;
      if (stray !== 0) begin
         n_fail++;
         $display("FAIL abort_no_result: got %0d active cycles expected 0", stray);
      end
      run_job(1'b0, 16'h0000, 1'b0, 1'b0);
      n_tests++;
      if (job_res !== 16'h1900 || job_nvalid !== 1) begin
         n_fail++;
         $display("FAIL abort_fresh_job: got %h (n=%0d) expected 1900", job_res, job_nvalid);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.keep_w = 1'b0; bus.bias = 16'h0000;
      bus.w_valid = 1'b0; bus.w_data = 16'h0000;
      test_reset();
      test_unity();
      test_negative();
      test_saturation();
      test_keep_w();
      test_gapped_weights();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
